fc1_requant_pack: RTL
=====================

// Module: fc1_requant_pack
// PURPOSE
//  Sits directly downstream of FC layer 1 and consumes its write-back stream (wren/addr/18b ReLU data, done pulse).
//  Requantizes each 18b non-negative activation to int8 by rounded right shift and saturation.
//  Packs 128 int8 lanes into 1024b words and writes them to the next FC layer's input-data RAM.
//  Pulses done once every word has been written.
// PARAMETERS
//  NUM_CH    128  activations per inference (multiple of LANES)
//  LANES     128  int8 lanes per output word (1024b = LANES*8)
//  WORDS     1    NUM_CH/LANES; output RAM words per inference
// PORTS
//  clk_i        in   1     clock, all logic on rising edge
//  rst_n_i      in   1     asynchronous active-low reset
//  start_i      in   1     1-cycle pulse: clear lanes/masks/error, enter COLLECT
//  shift_i      in   5     requant right-shift amount 0..17, sampled at start_i
//  in_wren_i    in   1     upstream activation valid
//  in_addr_i    in   7     channel index 0..NUM_CH-1
//  in_data_i    in   18    ReLU activation, unsigned
//  in_done_i    in   1     upstream last-channel pulse
//  out_wren_o   out  1     1-cycle write strobe to next-layer input RAM
//  out_addr_o   out  2     word address (channel/LANES)
//  out_data_o   out  1024  packed word, lane k at bits [8k+7:8k]
//  done_o       out  1     1-cycle pulse: inference fully packed and written
//  err_o        out  1     sticky: duplicate channel or done-before-complete
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; lane regs, masks, flushed flags, shift reg cleared.
//  FSM: IDLE -start_i-> COLLECT; COLLECT -all words flushed-> FIN; COLLECT -in_done_i with words unflushed-> DRAIN;
//   DRAIN -one word per cycle flushed, lowest index first-> FIN; FIN -> IDLE (done_o=1 for that one cycle).
//  start_i in any state: restart into COLLECT, clear everything, drop pending flushes, no done_o.
//  Inputs ignored in IDLE/FIN. in_wren_i with addr >= NUM_CH: ignored.
//  Stage 1 (edge E, in_wren_i sampled): q = (d + (s?1<<(s-1):0)) >> s, 19b sum, no overflow;
//   q8 = (q>127) ? 8'd127 : q[7:0]; lane[addr] <= q8; mask[addr/LANES][addr%LANES] <= 1.
//  Duplicate channel (mask bit already 1): lane overwritten with new value, err_o <= 1.
//  Stage 2 (edge E+1): word w with full mask and not flushed -> flush request.
//  Stage 3 (edge E+2): out_wren_o=1, out_addr_o=w, out_data_o=lanes of w; mark w flushed.
//   Lanes of the same inference are never written after their word has flushed.
//  Multiple words completing together: one flush per cycle, lowest index first; data held stable while wren=1.
//  Completion: edge after last flush -> FIN, done_o=1 for one cycle; in_done_i not required if all words complete.
//  in_done_i arriving while any word incomplete: err_o <= 1, DRAIN writes each unflushed word, missing lanes = 0.
//  in_done_i and a completing write in the same cycle: write is taken first, then done evaluated.
//  out_wren_o/out_data_o are registered outputs; out_data_o is held between writes (not cleared).
//  err_o clears only on reset or start_i.
// TESTING
//  shift=0, ch0..127 data=ch in order, in_done with ch127 -> one write at addr0, lane k=k, done_o 1 cycle after wren.
//  shift=4, data=0x00017 -> (23+8)>>4=1; data=0x3FFFF -> lane saturates to 127; data=8 -> 1 (round half up).
//  Channels in reverse order 127..0 -> write 2 cycles after ch0 sampled, identical packed word, err_o=0.
//  ch5 written twice (10, then 20) -> lane5=20, err_o=1, write still occurs once when mask full.
//  in_done after ch0..99 only -> err_o=1, DRAIN writes word with lanes 100..127 = 0, done_o pulses.
//  Async reset mid-COLLECT, then start_i with full stream -> no stale lanes, single clean write + done_o.

Source files
------------

// File: rtl/fc1_requant_pack.sv
// Requantizes FC1 ReLU write-back (18b unsigned) to saturated int8 and packs LANES lanes per RAM word.
// Latency: a word is written 2 edges after its last lane is sampled; done_o follows the last write by 1 cycle.
// No backpressure: upstream stream is accepted every cycle in COLLECT, output RAM write is fire-and-forget.
module fc1_requant_pack #(
  parameter int NUM_CH = 128,
  parameter int LANES  = 128,
  parameter int WORDS  = NUM_CH / LANES
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [4:0]        shift_i,
  input  logic              in_wren_i,
  input  logic [6:0]        in_addr_i,
  input  logic [17:0]       in_data_i,
  input  logic              in_done_i,
  output logic              out_wren_o,
  output logic [1:0]        out_addr_o,
  output logic [LANES*8-1:0] out_data_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_FIN     = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [4:0]               shift_q, shift_d;
  logic [NUM_CH-1:0][7:0]   lane_q, lane_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [WORDS-1:0]         flushed_q, flushed_d;
  logic [WORDS-1:0]         pend_q, pend_d;
  logic                     out_wren_q, out_wren_d;
  logic [1:0]               out_addr_q, out_addr_d;
  logic [LANES*8-1:0]       out_data_q, out_data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     addr_ok;
  logic [18:0]              rnd;
  logic [18:0]              sum;
  logic [18:0]              q;
  logic [7:0]               q8;

  // Out-of-range channel indices can only exist when NUM_CH does not fill the address space
  if (NUM_CH < 128) begin : g_addr_chk
    assign addr_ok = (int'(in_addr_i) < NUM_CH);
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  // Round-half-up right shift then clamp to int8 max; 19b sum cannot overflow for 18b data
  always_comb begin
    rnd = (shift_q != 5'd0) ? (19'd1 << (shift_q - 5'd1)) : 19'd0;
    sum = {1'b0, in_data_i} + rnd;
    q   = sum >> shift_q;
    q8  = (q > 19'd127) ? 8'd127 : q[7:0];
  end

  // Next-state: collect lanes, queue full words, emit one word per cycle, finish or drain
  always_comb begin
    logic found;
    logic incomplete;
    state_d    = state_q;
    shift_d    = shift_q;
    lane_d     = lane_q;
    mask_d     = mask_q;
    flushed_d  = flushed_q;
    pend_d     = pend_q;
    out_wren_d = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    found      = 1'b0;
    incomplete = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (&flushed_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          // Emit the lowest pending word (stage 3)
          for (int w = 0; w < WORDS; w++) begin
            if (pend_q[w] && !found) begin
              found        = 1'b1;
              pend_d[w]    = 1'b0;
              flushed_d[w] = 1'b1;
              out_wren_d   = 1'b1;
              out_addr_d   = 2'(w);
              out_data_d   = lane_q[w*LANES +: LANES];
            end
          end
          // Queue words whose mask filled on the previous edge (stage 2)
          for (int w = 0; w < WORDS; w++) begin
            if ((&mask_q[w*LANES +: LANES]) && !flushed_q[w] && !pend_q[w]) begin
              pend_d[w] = 1'b1;
            end
          end
          // Capture the incoming activation (stage 1); a repeat channel overwrites and flags
          if (in_wren_i && addr_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (in_addr_i == 7'(c)) begin
                lane_d[c] = q8;
                mask_d[c] = 1'b1;
                if (mask_q[c]) err_d = 1'b1;
              end
            end
          end
          // Done is judged after this cycle's write lands
          if (in_done_i) begin
            for (int w = 0; w < WORDS; w++) begin
              if (!(&mask_d[w*LANES +: LANES])) incomplete = 1'b1;
            end
            if (incomplete) begin
              err_d   = 1'b1;
              pend_d  = '0;
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (&flushed_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          // Write out unflushed words as they are; unwritten lanes stay zero from start
          for (int w = 0; w < WORDS; w++) begin
            if (!flushed_q[w] && !found) begin
              found        = 1'b1;
              flushed_d[w] = 1'b1;
              out_wren_d   = 1'b1;
              out_addr_d   = 2'(w);
              out_data_d   = lane_q[w*LANES +: LANES];
            end
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
      end
    endcase

    // start_i restarts from any state and abandons any flush in flight
    if (start_i) begin
      state_d    = S_COLLECT;
      shift_d    = shift_i;
      lane_d     = '0;
      mask_d     = '0;
      flushed_d  = '0;
      pend_d     = '0;
      out_wren_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      lane_q     <= '0;
      mask_q     <= '0;
      flushed_q  <= '0;
      pend_q     <= '0;
      out_wren_q <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      lane_q     <= lane_d;
      mask_q     <= mask_d;
      flushed_q  <= flushed_d;
      pend_q     <= pend_d;
      out_wren_q <= out_wren_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign out_wren_o = out_wren_q;
  assign out_addr_o = out_addr_q;
  assign out_data_o = out_data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
